// File: rtl/raw_capture_ctrl_if.sv
// Imager-side dtype stream: one data word, its dtype code and a valid strobe.
// The capture controller receives one of these streams and drives another
// (toward raw_to_32) with the same shape.
interface raw_capture_ctrl_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int DTYPE_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]  data;
    logic                   dv;
    logic [DTYPE_WIDTH-1:0] dtype;

    // Producer of the stream
    modport master (output data, output dv, output dtype);
    // Consumer of the stream
    modport slave  (input  data, input  dv, input  dtype);
endinterface

// File: rtl/raw_capture_ctrl.sv
// Frame-level capture sequencer in front of raw_to_32.
// Gates the imager dtype stream into whole frames according to the capture
// mode (off / single / continuous), applies frame decimation, drops whole
// frames when the downstream FIFO is almost full, and freezes the pack mode
// for each frame at its FRAME_START.
module raw_capture_ctrl #(
    parameter int                     DATA_WIDTH        = 16,
    parameter int                     CNT_WIDTH         = 16,
    parameter int                     DTYPE_WIDTH       = 4,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 'h1,
    parameter logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 'h2
) (
    input  logic                 clk,
    input  logic                 resetb,
    raw_capture_ctrl_if.slave    src,
    raw_capture_ctrl_if.master   dst,
    input  logic [1:0]           mode,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] skip,
    input  logic                 pack_req,
    input  logic                 fifo_afull,
    output logic                 pack,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic                 overrun
);

    localparam logic [1:0]           MODE_SINGLE = 2'd1;
    localparam logic [1:0]           MODE_CONT   = 2'd2;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        CAPTURE = 2'd2,
        DROP    = 2'd3
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   skip_cnt;
    logic                   stop_pend;

    logic [DATA_WIDTH-1:0]  data_p0;
    logic [DTYPE_WIDTH-1:0] dtype_p0;
    logic                   vld_p0;

    logic                   fs_in;
    logic                   fe_in;
    logic                   mode_run;
    logic                   stop_any;
    logic                   accept_fs;
    logic                   fwd;

    // Saturating increment for the drop counter
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign data_p0  = src.data;
    assign dtype_p0 = src.dtype;
    assign vld_p0   = src.dv;

    assign fs_in    = vld_p0 && (dtype_p0 == DTYPE_FRAME_START);
    assign fe_in    = vld_p0 && (dtype_p0 == DTYPE_FRAME_END);
    assign mode_run = (mode == MODE_SINGLE) || (mode == MODE_CONT);

    // Anything that ends the capture session at the next frame boundary:
    // a stop strobe now, one latched earlier, or mode switched to off/reserved.
    assign stop_any = stop || stop_pend || !mode_run;

    // A FRAME_START in WAIT_FS is forwarded only when no stop is in effect,
    // decimation is exhausted and the downstream FIFO has room.
    assign accept_fs = (state == WAIT_FS) && !stop_any && fs_in &&
                       (skip_cnt == '0) && !fifo_afull;

    assign fwd = accept_fs || ((state == CAPTURE) && vld_p0);

    // Output register stage: forwarded beats appear one cycle later; data and
    // dtype hold their last forwarded value while dv is low.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dst.data  <= '0;
            dst.dtype <= '0;
            dst.dv    <= 1'b0;
        end else begin
            dst.dv <= fwd;
            if (fwd) begin
                dst.data  <= data_p0;
                dst.dtype <= dtype_p0;
            end
        end
    end

    // Capture sequencer with registered status outputs and counters
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= IDLE;
            skip_cnt    <= '0;
            stop_pend   <= 1'b0;
            pack        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    // stop is meaningless here, so a simultaneous start wins
                    if (start && mode_run) begin
                        state     <= WAIT_FS;
                        busy      <= 1'b1;
                        skip_cnt  <= '0;
                        overrun   <= 1'b0;
                        stop_pend <= 1'b0;
                    end
                end

                WAIT_FS: begin
                    // Between frames a stop takes effect immediately
                    if (stop_any) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (fs_in) begin
                        if (skip_cnt != '0) begin
                            skip_cnt <= skip_cnt - CNT_ONE;
                            state    <= DROP;
                        end else if (fifo_afull) begin
                            drop_count <= sat_inc(drop_count);
                            state      <= DROP;
                        end else begin
                            pack  <= pack_req;
                            state <= CAPTURE;
                        end
                    end
                end

                CAPTURE: begin
                    // Frames are never truncated; backpressure is only flagged
                    if (fifo_afull) begin
                        overrun <= 1'b1;
                    end
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (fe_in) begin
                        frame_count <= frame_count + CNT_ONE;
                        skip_cnt    <= skip;
                        if ((mode != MODE_CONT) || stop || stop_pend) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= WAIT_FS;
                        end
                    end else if (fs_in) begin
                        // Lost FRAME_END: the new FRAME_START closes the previous
                        // frame and opens the next one; pack stays as latched.
                        frame_count <= frame_count + CNT_ONE;
                    end
                end

                DROP: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (fe_in) begin
                        if (stop_any) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= WAIT_FS;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
